new_patches_reader: RTL and testbench

// - Read-side engine for the 12-lane new-patches RAM bank (12 x 8-bit lanes, 2048 rows, shared row address).
// - On start, walks rows base_addr..base_addr+row_count-1 and streams every row out as 12 bytes, lane 0 first, on a valid/ready byte stream.
// - Sits between the patch RAM bank (port A read) and the downstream output/compare stage.

---
 rtl/new_patches_reader.sv | 215 +++++++++++++++++++++
 tb/tb_new_patches_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/new_patches_reader.sv
// new_patches_reader: walks RAM rows and streams each as 12 lane bytes on a valid/ready port. Rev 1.0
// Define NEW_PATCHES_READER_PREFETCH_EN to add a shadow row buffer that removes the inter-row bubble.
`default_nettype none

module new_patches_reader #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8,
   parameter int LANES  = 12,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   row_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_dout_p0,
   input  logic [DATA_W-1:0] ram_dout_p1,
   input  logic [DATA_W-1:0] ram_dout_p2,
   input  logic [DATA_W-1:0] ram_dout_p3,
   input  logic [DATA_W-1:0] ram_dout_p4,
   input  logic [DATA_W-1:0] ram_dout_p5,
   input  logic [DATA_W-1:0] ram_dout_p6,
   input  logic [DATA_W-1:0] ram_dout_p7,
   input  logic [DATA_W-1:0] ram_dout_p8,
   input  logic [DATA_W-1:0] ram_dout_p9,
   input  logic [DATA_W-1:0] ram_dout_p10,
   input  logic [DATA_W-1:0] ram_dout_p11,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [3:0]        m_lane,
   output logic              m_last
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WAIT  = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] ONE_ROW   = (ADDR_W+1)'(1);
   localparam logic [3:0]      LAST_LANE = 4'(LANES-1);
   localparam logic [1:0]      WAIT_INIT = 2'(RD_LAT-1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] row;
   logic [ADDR_W:0]   rows_left;
   logic [3:0]        lane;
   logic [1:0]        wait_cnt;
   logic [DATA_W-1:0] rd_lane [LANES];
   logic [DATA_W-1:0] act_buf [LANES];
   logic              hs, lane_end, last_row, wait_end;

`ifdef NEW_PATCHES_READER_PREFETCH_EN
   localparam logic [ADDR_W:0] TWO_ROWS = (ADDR_W+1)'(2);
   localparam logic [1:0]      PF_INIT  = 2'(RD_LAT);
   logic [DATA_W-1:0] shd_buf [LANES];
   logic [1:0]        pf_cnt;
   logic              pf_pend;
`endif

   assign rd_lane[0]  = ram_dout_p0;
   assign rd_lane[1]  = ram_dout_p1;
   assign rd_lane[2]  = ram_dout_p2;
   assign rd_lane[3]  = ram_dout_p3;
   assign rd_lane[4]  = ram_dout_p4;
   assign rd_lane[5]  = ram_dout_p5;
   assign rd_lane[6]  = ram_dout_p6;
   assign rd_lane[7]  = ram_dout_p7;
   assign rd_lane[8]  = ram_dout_p8;
   assign rd_lane[9]  = ram_dout_p9;
   assign rd_lane[10] = ram_dout_p10;
   assign rd_lane[11] = ram_dout_p11;

   assign hs       = (state == S_SHIFT) && m_ready;
   assign lane_end = hs && (lane == LAST_LANE);
   assign last_row = (rows_left == ONE_ROW);
   assign wait_end = (state == S_WAIT) && (wait_cnt == 2'd0);

   assign busy    = (state == S_ADDR) || (state == S_WAIT) || (state == S_SHIFT);
   assign done    = (state == S_DONE);
   assign m_valid = (state == S_SHIFT);
   assign m_lane  = lane;
   assign m_data  = m_valid ? act_buf[lane] : '0;
   assign m_last  = m_valid && (lane == LAST_LANE) && last_row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = (row_count == '0) ? S_DONE : S_ADDR;
            end
         end
         S_ADDR:  state_nx = S_WAIT;
         S_WAIT: begin
            if (wait_end) begin
               state_nx = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (lane_end) begin
`ifdef NEW_PATCHES_READER_PREFETCH_EN
               state_nx = last_row ? S_DONE : S_SHIFT;
`else
               state_nx = last_row ? S_DONE : S_ADDR;
`endif
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row       <= '0;
         rows_left <= '0;
         ram_addr  <= '0;
         lane      <= '0;
         wait_cnt  <= '0;
         for (int i = 0; i < LANES; i++) begin
            act_buf[i] <= '0;
         end
`ifdef NEW_PATCHES_READER_PREFETCH_EN
         for (int i = 0; i < LANES; i++) begin
            shd_buf[i] <= '0;
         end
         pf_cnt  <= '0;
         pf_pend <= 1'b0;
`endif
      end else begin
`ifdef NEW_PATCHES_READER_PREFETCH_EN
         // Shadow capture lands RD_LAT cycles after the prefetch address is issued.
         if (pf_pend) begin
            if (pf_cnt == 2'd0) begin
               shd_buf <= rd_lane;
               pf_pend <= 1'b0;
            end else begin
               pf_cnt <= pf_cnt - 2'd1;
            end
         end
`endif
         case (state)
            S_IDLE: begin
               if (start) begin
                  row       <= base_addr;
                  rows_left <= row_count;
                  lane      <= '0;
                  if (row_count != '0) begin
                     ram_addr <= base_addr;
                  end
               end
            end
            S_ADDR: wait_cnt <= WAIT_INIT;
            S_WAIT: begin
               if (wait_end) begin
                  act_buf <= rd_lane;
                  lane    <= '0;
`ifdef NEW_PATCHES_READER_PREFETCH_EN
                  if (!last_row) begin
                     ram_addr <= row + 1'b1;
                     pf_cnt   <= PF_INIT;
                     pf_pend  <= 1'b1;
                  end
`endif
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            S_SHIFT: begin
               if (hs) begin
                  if (lane_end) begin
                     lane <= '0;
                     if (!last_row) begin
                        row       <= row + 1'b1;
                        rows_left <= rows_left - ONE_ROW;
`ifdef NEW_PATCHES_READER_PREFETCH_EN
                        act_buf <= shd_buf;
                        // Only prefetch while a row beyond the one being promoted exists.
                        if (rows_left != TWO_ROWS) begin
                           ram_addr <= row + 2'd2;
                           pf_cnt   <= PF_INIT;
                           pf_pend  <= 1'b1;
                        end
`else
                        ram_addr <= row + 1'b1;
`endif
                     end
                  end else begin
                     lane <= lane + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_new_patches_reader.sv
// tb_new_patches_reader: directed scoreboard bench for new_patches_reader with a RD_LAT=2 RAM model.
`timescale 1ns/1ps
`default_nettype none

module tb_new_patches_reader;

   localparam int ADDR_W = 11;
   localparam int RD_LAT = 2;
`ifdef NEW_PATCHES_READER_PREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] lane;
      logic       last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              m_ready = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   row_count = '0;
   logic              busy, done, m_valid, m_last;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        m_data;
   logic [3:0]        m_lane;
   logic [ADDR_W-1:0] pipe [RD_LAT];
   logic [7:0]        dout [12];

   int    checks = 0;
   int    errors = 0;
   bit    rand_ready = 1'b0;
   beat_t sb[$];
   beat_t prev_beat, obs_beat, want_beat;
   bit    stalled = 1'b0;
   int    k;

   new_patches_reader #(.ADDR_W(ADDR_W), .DATA_W(8), .LANES(12), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .row_count(row_count),
      .busy(busy), .done(done), .ram_addr(ram_addr),
      .ram_dout_p0(dout[0]), .ram_dout_p1(dout[1]), .ram_dout_p2(dout[2]), .ram_dout_p3(dout[3]),
      .ram_dout_p4(dout[4]), .ram_dout_p5(dout[5]), .ram_dout_p6(dout[6]), .ram_dout_p7(dout[7]),
      .ram_dout_p8(dout[8]), .ram_dout_p9(dout[9]), .ram_dout_p10(dout[10]), .ram_dout_p11(dout[11]),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_lane(m_lane), .m_last(m_last)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] lane_val(input int r, input int l);
      return 8'((r * 12 + l) & 255);
   endfunction

   // RAM bank model: read data appears RD_LAT cycles after the address.
   always @(posedge clk) begin
      pipe[0] <= ram_addr;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   always_comb begin
      for (int l = 0; l < 12; l++) dout[l] = lane_val(int'(pipe[RD_LAT-1]), l);
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({busy, done, m_valid, m_last, m_data, m_lane, ram_addr});
   endfunction

   function automatic int exp_done_k(input int n);
      if (n == 0) return 1;
      return PF ? (1 + RD_LAT + 12 * n + 1) : (n * (13 + RD_LAT) + 1);
   endfunction

   // Output monitor: pops the scoreboard on each handshake and checks stall stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         obs_beat = '{data: m_data, lane: m_lane, last: m_last};
         if (stalled) begin
            chk("valid_held", 32'(m_valid), 32'd1);
            if (m_valid) chk("stall_hold", 32'(obs_beat), 32'(prev_beat));
         end
         stalled = 1'b0;
         if (m_valid) begin
            if (m_ready) begin
               chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  want_beat = sb.pop_front();
                  chk("beat", 32'(obs_beat), 32'(want_beat));
               end
            end else begin
               stalled   = 1'b1;
               prev_beat = obs_beat;
            end
         end
      end
   end

   task automatic start_job(input int base, input int cnt);
      for (int r = 0; r < cnt; r++) begin
         for (int l = 0; l < 12; l++) begin
            sb.push_back('{data: lane_val((base + r) % 2048, l), lane: 4'(l), last: (r == cnt - 1) && (l == 11)});
         end
      end
      @(posedge clk);
      #2;
      base_addr = ADDR_W'(base);
      row_count = (ADDR_W+1)'(cnt);
      start     = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input int mid, output int kk);
      kk = 0;
      do begin
         @(negedge clk);
         kk++;
         start = (kk == mid);
         if (kk == mid) begin
            base_addr = 11'd100;
            row_count = 12'd1;
         end
      end while (done !== 1'b1 && kk < 3000);
      start = 1'b0;
      chk("done_seen", 32'(done), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      // Held in reset with a start pulse that must be ignored.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 5) begin
            base_addr = 11'd5;
            row_count = 12'd3;
            start     = 1'b1;
         end
         if (i == 7) start = 1'b0;
         chk("reset_outs", outs(), 32'd0);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_after_reset", outs(), 32'd0);
      end

      start_job(5, 3);
      wait_done(0, k);
      chk("latency_5x3", 32'(k), 32'(exp_done_k(3)));

      rand_ready = 1'b1;
      start_job(5, 3);
      wait_done(0, k);
      rand_ready = 1'b0;

      start_job(2047, 2);
      wait_done(0, k);
      chk("latency_wrap", 32'(k), 32'(exp_done_k(2)));

      start_job(0, 0);
      wait_done(0, k);
      chk("latency_zero", 32'(k), 32'(exp_done_k(0)));

      start_job(10, 4);
      wait_done(0, k);
      chk("latency_4rows", 32'(k), 32'(exp_done_k(4)));

      start_job(20, 2);
      wait_done(15, k);
      chk("latency_midstart", 32'(k), 32'(exp_done_k(2)));

      // Reset asserted mid-row aborts at once with no done pulse.
      start_job(30, 2);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_outs", outs(), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'd0);
      end
      sb.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      rand_ready = 1'b1;
      start_job(1000, 2);
      wait_done(0, k);
      rand_ready = 1'b0;

      start_job(1, 1);
      wait_done(0, k);
      chk("latency_1row", 32'(k), 32'(exp_done_k(1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
